ram_16x8: RTL and testbench

RAM_16X8 -- requirements
Module: ram_16x8

---
 rtl/cpu_pkg.sv | 17 +
 rtl/ram_core.sv | 39 +++
 rtl/ram_16x8.sv | 130 +++++++++++++
 tb/tb_ram_16x8.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared bus widths and RAM controller state encoding
//
// Purpose : common definitions for the MAR, the RAM and other bus blocks.
// Contents: ADDR_W / DATA_W defaults, ram_state_t FSM enumeration.

package cpu_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_PROG  = 2'd2
    } ram_state_t;

endpackage

// File: rtl/ram_core.sv
// rtl/ram_core.sv - single-port synchronous array with registered read data
//
// Purpose : DATA_W x 2^ADDR_W storage, one shared address for write and read.
// Ports   : clk, rst (sync, active-high, clears only the read register),
//           addr, we/wdata (write at the edge), re (load rdata at the edge),
//           rdata (registered read data, holds when re=0).

module ram_core #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Array contents are never reset; zeroing is done by the owner's sweep.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read and write share an edge, so a read returns the pre-write word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_16x8.sv
// rtl/ram_16x8.sv - bus RAM with power-on clear sweep and program-load mode
//
// Purpose : CPU-visible RAM addressed by the MAR, plus a loader port used to
//           fill memory while the CPU is held off.
// Ports   : clk, rst (sync, active-high)
//           CPU side   : mar_add_4, ram_in, ram_out, bus_in_8 -> ram_bus_8, ram_bus_oe
//           loader side: prog_mode, prog_valid, prog_addr_4, prog_data_8
//                        -> prog_ready, prog_done
//           status     : busy (CLEAR or PROG; CPU control ignored)

module ram_16x8 #(
    parameter int ADDR_W         = cpu_pkg::ADDR_W,
    parameter int DATA_W         = cpu_pkg::DATA_W,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mar_add_4,
    input  logic              ram_in,
    input  logic              ram_out,
    input  logic [DATA_W-1:0] bus_in_8,
    output logic [DATA_W-1:0] ram_bus_8,
    output logic              ram_bus_oe,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [ADDR_W-1:0] prog_addr_4,
    input  logic [DATA_W-1:0] prog_data_8,
    output logic              prog_ready,
    output logic              prog_done,
    output logic              busy
);

    import cpu_pkg::*;

    localparam ram_state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    ram_state_t        state;
    logic [ADDR_W-1:0] sweep;

    logic [ADDR_W-1:0] core_addr;
    logic              core_we;
    logic [DATA_W-1:0] core_wdata;
    logic              core_re;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RESET_STATE;
            sweep      <= '0;
            ram_bus_oe <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    ram_bus_oe <= 1'b0;
                    // Natural wrap returns the counter to 0 as CLEAR ends.
                    sweep      <= sweep + 1'b1;
                    if (sweep == '1) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    ram_bus_oe <= ram_out;
                    if (prog_mode) begin
                        state <= ST_PROG;
                    end
                end
                ST_PROG: begin
                    ram_bus_oe <= 1'b0;
                    if (!prog_mode) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state      <= RESET_STATE;
                    ram_bus_oe <= 1'b0;
                end
            endcase
        end
    end

    // The loader only takes words while it is staying in PROG; the exit
    // cycle (prog_mode already low) reports done instead of ready.
    assign prog_ready = (state == ST_PROG) && prog_mode;
    assign prog_done  = (state == ST_PROG) && !prog_mode;
    assign busy       = (state != ST_RUN);

    always_comb begin
        core_addr  = mar_add_4;
        core_wdata = bus_in_8;
        core_we    = 1'b0;
        core_re    = 1'b0;
        case (state)
            ST_CLEAR: begin
                core_addr  = sweep;
                core_wdata = '0;
                core_we    = 1'b1;
            end
            ST_RUN: begin
                core_we = ram_in;
                core_re = ram_out;
            end
            ST_PROG: begin
                core_addr  = prog_addr_4;
                core_wdata = prog_data_8;
                core_we    = prog_valid && prog_ready;
            end
            default: begin
                core_we = 1'b0;
            end
        endcase
        // Reset wins over every write source.
        if (rst) begin
            core_we = 1'b0;
            core_re = 1'b0;
        end
    end

    ram_core #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .addr  (core_addr),
        .we    (core_we),
        .wdata (core_wdata),
        .re    (core_re),
        .rdata (ram_bus_8)
    );

endmodule

// File: tb/tb_ram_16x8.sv
// tb/tb_ram_16x8.sv - self-checking bench for ram_16x8

module tb_ram_16x8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] mar_add_4;
    logic       ram_in;
    logic       ram_out;
    logic [7:0] bus_in_8;
    logic [7:0] ram_bus_8;
    logic       ram_bus_oe;
    logic       prog_mode;
    logic       prog_valid;
    logic [3:0] prog_addr_4;
    logic [7:0] prog_data_8;
    logic       prog_ready;
    logic       prog_done;
    logic       busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_16x8 dut (
        .clk         (clk),
        .rst         (rst),
        .mar_add_4   (mar_add_4),
        .ram_in      (ram_in),
        .ram_out     (ram_out),
        .bus_in_8    (bus_in_8),
        .ram_bus_8   (ram_bus_8),
        .ram_bus_oe  (ram_bus_oe),
        .prog_mode   (prog_mode),
        .prog_valid  (prog_valid),
        .prog_addr_4 (prog_addr_4),
        .prog_data_8 (prog_data_8),
        .prog_ready  (prog_ready),
        .prog_done   (prog_done),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: remaining clear cycles, a program-mode flag, and an array.
    int         clear_left = 0;
    bit         in_prog    = 1'b0;
    bit         armed      = 1'b0;
    logic [7:0] mem_m [16];
    logic [7:0] exp_bus;
    bit         exp_oe;

    always @(posedge clk) begin
        if (rst) begin
            clear_left = 16;
            in_prog    = 1'b0;
            exp_bus    = 8'h00;
            exp_oe     = 1'b0;
            armed      = 1'b1;
        end else if (clear_left > 0) begin
            mem_m[16 - clear_left] = 8'h00;
            clear_left--;
            exp_oe = 1'b0;
        end else if (!in_prog) begin
            exp_oe = ram_out;
            if (ram_out) exp_bus = mem_m[mar_add_4];
            if (ram_in) mem_m[mar_add_4] = bus_in_8;
            if (prog_mode) in_prog = 1'b1;
        end else begin
            exp_oe = 1'b0;
            if (prog_mode && prog_valid) mem_m[prog_addr_4] = prog_data_8;
            if (!prog_mode) in_prog = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("bus",   {24'd0, ram_bus_8},  {24'd0, exp_bus});
            check("oe",    {31'd0, ram_bus_oe}, {31'd0, exp_oe});
            check("busy",  {31'd0, busy},       {31'd0, (clear_left > 0) || in_prog});
            check("ready", {31'd0, prog_ready}, {31'd0, in_prog && prog_mode});
            check("done",  {31'd0, prog_done},  {31'd0, in_prog && !prog_mode});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ram_in = 0; ram_out = 0; prog_valid = 0;
    endtask

    task automatic read_word(input logic [3:0] a, input logic [7:0] exp, input string name);
        mar_add_4 = a; ram_in = 0; ram_out = 1;
        cyc();
        check(name, {24'd0, ram_bus_8}, {24'd0, exp});
        check({name, "_oe"}, {31'd0, ram_bus_oe}, 32'd1);
        ram_out = 0;
    endtask

    task automatic do_reset_and_time_clear(input string name);
        int n;
        rst = 1; prog_mode = 0; idle_inputs();
        cyc();
        check({name, "_rst_bus"}, {24'd0, ram_bus_8}, 32'd0);
        check({name, "_rst_oe"}, {31'd0, ram_bus_oe}, 32'd0);
        check({name, "_rst_busy"}, {31'd0, busy}, 32'd1);
        check({name, "_rst_ready"}, {31'd0, prog_ready}, 32'd0);
        rst = 0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            cyc();
        end
        check({name, "_clear_len"}, n, 32'd16);
    endtask

    initial begin
        int n;
        rst = 1; mar_add_4 = 0; bus_in_8 = 0; prog_mode = 0;
        prog_addr_4 = 0; prog_data_8 = 0; idle_inputs();
        cyc();
        do_reset_and_time_clear("init");

        for (int a = 0; a < 16; a++) read_word(4'(a), 8'h00, "cleared");

        // Write then read back.
        mar_add_4 = 6; bus_in_8 = 8'hA5; ram_in = 1; cyc();
        read_word(4'd6, 8'hA5, "wr_rd_6");

        // Read-before-write on the same edge.
        mar_add_4 = 10; bus_in_8 = 8'h11; ram_in = 1; cyc();
        bus_in_8 = 8'h3C; ram_in = 1; ram_out = 1; cyc();
        check("rbw_old", {24'd0, ram_bus_8}, 32'h11);
        read_word(4'd10, 8'h3C, "rbw_new");

        // Idle address change holds bus and drops oe.
        mar_add_4 = 3; idle_inputs(); cyc();
        check("hold_bus", {24'd0, ram_bus_8}, 32'h3C);
        check("hold_oe", {31'd0, ram_bus_oe}, 32'd0);

        // Program mode load.
        prog_mode = 1; cyc();
        check("prog_ready", {31'd0, prog_ready}, 32'd1);
        prog_valid = 1; prog_addr_4 = 0; prog_data_8 = 8'h1E;
        mar_add_4 = 5; bus_in_8 = 8'hFF; ram_in = 1; ram_out = 1;
        cyc();
        check("prog_oe", {31'd0, ram_bus_oe}, 32'd0);
        prog_addr_4 = 15; prog_data_8 = 8'hF0; cyc();
        ram_in = 0; ram_out = 0;
        prog_mode = 0; prog_addr_4 = 1; prog_data_8 = 8'h77;
        #1;
        check("exit_done", {31'd0, prog_done}, 32'd1);
        check("exit_ready", {31'd0, prog_ready}, 32'd0);
        cyc();
        prog_valid = 0;
        check("after_done", {31'd0, prog_done}, 32'd0);
        check("after_busy", {31'd0, busy}, 32'd0);
        read_word(4'd0, 8'h1E, "prog_w0");
        read_word(4'd15, 8'hF0, "prog_w15");
        read_word(4'd5, 8'h00, "cpu_ignored");
        read_word(4'd1, 8'h00, "exit_not_taken");

        // Randomized traffic checked by the compare process.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            mar_add_4 = 4'($urandom);
            bus_in_8 = 8'($urandom);
            ram_in = ($urandom_range(0, 2) == 0);
            ram_out = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 19) == 0) prog_mode = ~prog_mode;
            prog_valid = 1'($urandom);
            prog_addr_4 = 4'($urandom);
            prog_data_8 = 8'($urandom);
            cyc();
        end
        rst = 0; prog_mode = 0; idle_inputs();
        repeat (20) cyc();

        // Reset in the middle of CLEAR.
        rst = 1; cyc(); rst = 0;
        repeat (8) cyc();
        check("mid_clear_busy", {31'd0, busy}, 32'd1);
        do_reset_and_time_clear("mid_clear");

        // Reset in the middle of PROG.
        prog_mode = 1; cyc(); cyc();
        check("in_prog_ready", {31'd0, prog_ready}, 32'd1);
        do_reset_and_time_clear("mid_prog");

        // prog_mode during CLEAR is held off until CLEAR completes.
        rst = 1; cyc(); rst = 0;
        prog_mode = 1;
        n = 0;
        while (prog_ready !== 1'b1 && n < 40) begin
            n++;
            cyc();
        end
        check("prog_holdoff", n, 32'd17);
        prog_mode = 0; cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
